mem_arbiter: RTL and testbench

Sits between the three memory requesters (instruction-fetch line refill, LSB load, LSB committed-store) and the byte-serial memory controller. Grants one transaction at a time by fixed priority with a fetch anti-starvation override, and registers the downstream request. Routes completion back to the owning requester. Handles rollback by cancelling speculative fetch and load traffic, while committed stores always complete.

---
 rtl/mem_arbiter.sv | 241 ++++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates fetch-line, load and committed-store requests onto the byte-serial
// memory controller, one transaction at a time, with fetch anti-starvation and rollback.
module mem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int LINE_BYTES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    rollback,

    input  logic                    if_req,
    input  logic [31:0]             if_addr,
    output logic                    if_done,
    output logic [8*LINE_BYTES-1:0] if_data,

    input  logic                    ld_req,
    input  logic [31:0]             ld_addr,
    input  logic [2:0]              ld_len,
    output logic                    ld_done,
    output logic [31:0]             ld_data,

    input  logic                    st_req,
    input  logic [31:0]             st_addr,
    input  logic [2:0]              st_len,
    input  logic [31:0]             st_data,
    output logic                    st_done,

    output logic                    mc_en,
    output logic                    mc_if,
    output logic                    mc_wr,
    output logic [31:0]             mc_addr,
    output logic [2:0]              mc_len,
    output logic [31:0]             mc_wdata,
    input  logic                    mc_if_done,
    input  logic [8*LINE_BYTES-1:0] mc_if_data,
    input  logic                    mc_lsb_done,
    input  logic [31:0]             mc_lsb_rdata
);
    localparam int LINE_W = 8 * LINE_BYTES;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [1:0] OWN_FETCH = 2'd0;
    localparam logic [1:0] OWN_LOAD  = 2'd1;
    localparam logic [1:0] OWN_STORE = 2'd2;

    localparam logic [3:0] STREAK_LIMIT = 4'(STARVE_MAX);

    logic [1:0]        state_q,   state_d;
    logic [1:0]        owner_q,   owner_d;
    logic [3:0]        streak_q,  streak_d;
    logic              mcEn_q,    mcEn_d;
    logic              mcIf_q,    mcIf_d;
    logic              mcWr_q,    mcWr_d;
    logic [31:0]       mcAddr_q,  mcAddr_d;
    logic [2:0]        mcLen_q,   mcLen_d;
    logic [31:0]       mcWdata_q, mcWdata_d;
    logic              ifDone_q,  ifDone_d;
    logic              ldDone_q,  ldDone_d;
    logic              stDone_q,  stDone_d;
    logic [LINE_W-1:0] ifData_q,  ifData_d;
    logic [31:0]       ldData_q,  ldData_d;

    logic grantFetch;
    logic grantLoad;
    logic grantStore;
    logic ownerDone;
    logic cancel;

    // A waiting fetch that has been passed over STARVE_MAX times jumps the queue.
    always_comb begin
        grantFetch = 1'b0;
        grantLoad  = 1'b0;
        grantStore = 1'b0;
        if (state_q == ST_IDLE && !rollback) begin
            if (if_req && streak_q == STREAK_LIMIT) begin
                grantFetch = 1'b1;
            end else if (st_req) begin
                grantStore = 1'b1;
            end else if (ld_req) begin
                grantLoad = 1'b1;
            end else if (if_req) begin
                grantFetch = 1'b1;
            end
        end
    end

    always_comb begin
        ownerDone = (owner_q == OWN_FETCH) ? mc_if_done : mc_lsb_done;
        cancel    = rollback && (owner_q != OWN_STORE);
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        streak_d  = streak_q;
        mcEn_d    = mcEn_q;
        mcIf_d    = mcIf_q;
        mcWr_d    = mcWr_q;
        mcAddr_d  = mcAddr_q;
        mcLen_d   = mcLen_q;
        mcWdata_d = mcWdata_q;
        ifDone_d  = 1'b0;
        ldDone_d  = 1'b0;
        stDone_d  = 1'b0;
        ifData_d  = ifData_q;
        ldData_d  = ldData_q;

        if (!if_req || grantFetch) begin
            streak_d = 4'd0;
        end else if ((grantLoad || grantStore) && streak_q != STREAK_LIMIT) begin
            streak_d = streak_q + 4'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (grantFetch) begin
                    state_d   = ST_BUSY;
                    owner_d   = OWN_FETCH;
                    mcEn_d    = 1'b1;
                    mcIf_d    = 1'b1;
                    mcWr_d    = 1'b0;
                    mcAddr_d  = if_addr;
                    mcLen_d   = 3'd0;
                    mcWdata_d = 32'd0;
                end else if (grantStore) begin
                    state_d   = ST_BUSY;
                    owner_d   = OWN_STORE;
                    mcEn_d    = 1'b1;
                    mcIf_d    = 1'b0;
                    mcWr_d    = 1'b1;
                    mcAddr_d  = st_addr;
                    mcLen_d   = st_len;
                    mcWdata_d = st_data;
                end else if (grantLoad) begin
                    state_d   = ST_BUSY;
                    owner_d   = OWN_LOAD;
                    mcEn_d    = 1'b1;
                    mcIf_d    = 1'b0;
                    mcWr_d    = 1'b0;
                    mcAddr_d  = ld_addr;
                    mcLen_d   = ld_len;
                    mcWdata_d = 32'd0;
                end
            end

            ST_BUSY: begin
                if (cancel) begin
                    // A cancelled fetch still owes us one mc_if_done unless it lands right now.
                    mcEn_d  = 1'b0;
                    mcIf_d  = 1'b0;
                    mcWr_d  = 1'b0;
                    state_d = (owner_q == OWN_FETCH && !mc_if_done) ? ST_DRAIN : ST_IDLE;
                end else if (ownerDone) begin
                    mcEn_d  = 1'b0;
                    mcIf_d  = 1'b0;
                    mcWr_d  = 1'b0;
                    state_d = ST_IDLE;
                    case (owner_q)
                        OWN_FETCH: begin
                            ifDone_d = 1'b1;
                            ifData_d = mc_if_data;
                        end
                        OWN_LOAD: begin
                            ldDone_d = 1'b1;
                            ldData_d = mc_lsb_rdata;
                        end
                        default: begin
                            stDone_d = 1'b1;
                        end
                    endcase
                end
            end

            ST_DRAIN: begin
                if (mc_if_done) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // While rdy is low everything holds except the done pulses, which are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_FETCH;
            streak_q  <= 4'd0;
            mcEn_q    <= 1'b0;
            mcIf_q    <= 1'b0;
            mcWr_q    <= 1'b0;
            mcAddr_q  <= 32'd0;
            mcLen_q   <= 3'd0;
            mcWdata_q <= 32'd0;
            ifDone_q  <= 1'b0;
            ldDone_q  <= 1'b0;
            stDone_q  <= 1'b0;
            ifData_q  <= '0;
            ldData_q  <= 32'd0;
        end else if (rdy) begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            streak_q  <= streak_d;
            mcEn_q    <= mcEn_d;
            mcIf_q    <= mcIf_d;
            mcWr_q    <= mcWr_d;
            mcAddr_q  <= mcAddr_d;
            mcLen_q   <= mcLen_d;
            mcWdata_q <= mcWdata_d;
            ifDone_q  <= ifDone_d;
            ldDone_q  <= ldDone_d;
            stDone_q  <= stDone_d;
            ifData_q  <= ifData_d;
            ldData_q  <= ldData_d;
        end else begin
            ifDone_q  <= 1'b0;
            ldDone_q  <= 1'b0;
            stDone_q  <= 1'b0;
        end
    end

    assign if_done  = ifDone_q & rdy;
    assign ld_done  = ldDone_q & rdy;
    assign st_done  = stDone_q & rdy;
    assign if_data  = ifData_q;
    assign ld_data  = ldData_q;
    assign mc_en    = mcEn_q;
    assign mc_if    = mcIf_q;
    assign mc_wr    = mcWr_q;
    assign mc_addr  = mcAddr_q;
    assign mc_len   = mcLen_q;
    assign mc_wdata = mcWdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vectors, corner-case sequences
// and a randomized run against a transaction-level reference model.
module tb_mem_arbiter;
    localparam int STARVE = 4;
    localparam int LB     = 64;
    localparam int LW     = 8 * LB;

    localparam int WHO_FETCH = 0;
    localparam int WHO_LOAD  = 1;
    localparam int WHO_STORE = 2;

    logic          clk = 1'b0;
    logic          rst, rdy, rollback;
    logic          ifReq, ifDone;
    logic [31:0]   ifAddr;
    logic [LW-1:0] ifData;
    logic          ldReq, ldDone;
    logic [31:0]   ldAddr, ldData;
    logic [2:0]    ldLen;
    logic          stReq, stDone;
    logic [31:0]   stAddr, stData;
    logic [2:0]    stLen;
    logic          mcEn, mcIf, mcWr;
    logic [31:0]   mcAddr, mcWdata;
    logic [2:0]    mcLen;
    logic          mcIfDone, mcLsbDone;
    logic [LW-1:0] mcIfData;
    logic [31:0]   mcLsbRdata;

    int compared   = 0;
    int mismatched = 0;

    logic [LW-1:0] lineA, lineB;

    mem_arbiter #(.STARVE_MAX(STARVE), .LINE_BYTES(LB)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .if_req(ifReq), .if_addr(ifAddr), .if_done(ifDone), .if_data(ifData),
        .ld_req(ldReq), .ld_addr(ldAddr), .ld_len(ldLen), .ld_done(ldDone), .ld_data(ldData),
        .st_req(stReq), .st_addr(stAddr), .st_len(stLen), .st_data(stData), .st_done(stDone),
        .mc_en(mcEn), .mc_if(mcIf), .mc_wr(mcWr), .mc_addr(mcAddr), .mc_len(mcLen),
        .mc_wdata(mcWdata), .mc_if_done(mcIfDone), .mc_if_data(mcIfData),
        .mc_lsb_done(mcLsbDone), .mc_lsb_rdata(mcLsbRdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Ticks until mc_en rises or the budget runs out; an expired budget is a failed check.
    task automatic waitGrant(input string name, input int maxCycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < maxCycles && !seen; i++) begin
            tick();
            if (mcEn) seen = 1'b1;
        end
        checkOutput({name, " grant"}, mcEn, 1'b1);
    endtask

    typedef struct {
        bit          isStore;
        logic [31:0] addr;
        logic [2:0]  len;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        expWr;
        logic [31:0] expAddr;
        logic [2:0]  expLen;
        logic [31:0] expWdata;
        logic [31:0] expLdData;
    } lsbVec_t;

    task automatic applyStimulus(input int idx, input lsbVec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        if (v.isStore) begin
            stReq = 1'b1; stAddr = v.addr; stLen = v.len; stData = v.wdata;
        end else begin
            ldReq = 1'b1; ldAddr = v.addr; ldLen = v.len;
        end
        waitGrant(tag, 4);
        checkOutput({tag, " mcWr"},   mcWr,   v.expWr);
        checkOutput({tag, " mcIf"},   mcIf,   1'b0);
        checkOutput({tag, " mcAddr"}, mcAddr, v.expAddr);
        checkOutput({tag, " mcLen"},  mcLen,  v.expLen);
        if (v.isStore) checkOutput({tag, " mcWdata"}, mcWdata, v.expWdata);
        ldAddr = ~v.addr; stAddr = ~v.addr; stData = ~v.wdata; ldLen = 3'd1; stLen = 3'd1;
        tick();
        tick();
        checkOutput({tag, " addrHeld"}, mcAddr, v.expAddr);
        checkOutput({tag, " lenHeld"},  mcLen,  v.expLen);
        mcLsbRdata = v.rdata;
        mcLsbDone  = 1'b1;
        tick();
        mcLsbDone = 1'b0; stReq = 1'b0; ldReq = 1'b0;
        checkOutput({tag, " mcEnCleared"}, mcEn, 1'b0);
        checkOutput({tag, " stDone"}, stDone, v.isStore);
        checkOutput({tag, " ldDone"}, ldDone, !v.isStore);
        if (!v.isStore) checkOutput({tag, " ldData"}, ldData, v.expLdData);
        tick();
        checkOutput({tag, " donesLow"}, {ldDone, stDone, ifDone}, 3'b000);
    endtask

    // ---------------- transaction-level reference model ----------------
    typedef struct {
        int          who;
        bit          cancelled;
        logic [31:0] addr;
        logic [2:0]  len;
        logic [31:0] wdata;
    } txn_t;

    txn_t          active[$];
    int            mStreak;
    int            expDoneWho;
    logic [LW-1:0] expIfData;
    logic [31:0]   expLdData;

    function automatic int pickRequester();
        if (ifReq && mStreak >= STARVE) return WHO_FETCH;
        if (stReq) return WHO_STORE;
        if (ldReq) return WHO_LOAD;
        if (ifReq) return WHO_FETCH;
        return -1;
    endfunction

    function automatic void modelEdge();
        int   granted;
        txn_t t;
        granted    = -1;
        expDoneWho = -1;
        if (rst) begin
            active.delete();
            mStreak   = 0;
            expIfData = '0;
            expLdData = '0;
            return;
        end
        if (!rdy) return;
        if (active.size() == 0) begin
            if (!rollback) begin
                granted     = pickRequester();
                t.who       = granted;
                t.cancelled = 1'b0;
                t.addr      = (granted == WHO_FETCH) ? ifAddr : (granted == WHO_LOAD) ? ldAddr : stAddr;
                t.len       = (granted == WHO_LOAD) ? ldLen : (granted == WHO_STORE) ? stLen : 3'd0;
                t.wdata     = (granted == WHO_STORE) ? stData : 32'd0;
                if (granted >= 0) active.push_back(t);
            end
        end else begin
            t = active[0];
            if (t.cancelled) begin
                if (mcIfDone) active.delete();
            end else if (rollback && t.who != WHO_STORE) begin
                if (t.who == WHO_FETCH && !mcIfDone) active[0].cancelled = 1'b1;
                else active.delete();
            end else if ((t.who == WHO_FETCH) ? mcIfDone : mcLsbDone) begin
                expDoneWho = t.who;
                if (t.who == WHO_FETCH) expIfData = mcIfData;
                if (t.who == WHO_LOAD)  expLdData = mcLsbRdata;
                active.delete();
            end
        end
        if (!ifReq || granted == WHO_FETCH) mStreak = 0;
        else if (granted == WHO_LOAD || granted == WHO_STORE) mStreak = (mStreak < STARVE) ? mStreak + 1 : STARVE;
    endfunction

    task automatic compareModel(input int cyc);
        bit expEn;
        expEn = (active.size() != 0) && !active[0].cancelled;
        checkOutput($sformatf("rnd%0d mcEn", cyc), mcEn, expEn);
        if (expEn) begin
            checkOutput($sformatf("rnd%0d mcIf", cyc),   mcIf,   active[0].who == WHO_FETCH);
            checkOutput($sformatf("rnd%0d mcWr", cyc),   mcWr,   active[0].who == WHO_STORE);
            checkOutput($sformatf("rnd%0d mcAddr", cyc), mcAddr, active[0].addr);
            if (active[0].who != WHO_FETCH) checkOutput($sformatf("rnd%0d mcLen", cyc), mcLen, active[0].len);
            if (active[0].who == WHO_STORE) checkOutput($sformatf("rnd%0d mcWdata", cyc), mcWdata, active[0].wdata);
        end
        checkOutput($sformatf("rnd%0d dones", cyc), {ifDone, ldDone, stDone},
                    {expDoneWho == WHO_FETCH, expDoneWho == WHO_LOAD, expDoneWho == WHO_STORE});
        if (expDoneWho == WHO_FETCH) checkOutput($sformatf("rnd%0d ifData", cyc), ifData, expIfData);
        if (expDoneWho == WHO_LOAD)  checkOutput($sformatf("rnd%0d ldData", cyc), ldData, expLdData);
    endtask

    lsbVec_t vecs[5];
    int      quietBad;

    initial begin
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
        ifReq = 1'b0; ifAddr = '0; ldReq = 1'b0; ldAddr = '0; ldLen = 3'd0;
        stReq = 1'b0; stAddr = '0; stLen = 3'd0; stData = '0;
        mcIfDone = 1'b0; mcIfData = '0; mcLsbDone = 1'b0; mcLsbRdata = '0;
        for (int w = 0; w < LW / 32; w++) begin
            lineA[w*32 +: 32] = 32'hA000_0000 + 32'(w);
            lineB[w*32 +: 32] = 32'hB000_0000 + 32'(w);
        end

        vecs[0] = '{1'b0, 32'h0000_1004, 3'd4, 32'h0,         32'hDEAD_BEEF, 1'b0, 32'h0000_1004, 3'd4, 32'h0,         32'hDEAD_BEEF};
        vecs[1] = '{1'b0, 32'h0000_2001, 3'd1, 32'h0,         32'h0000_00A5, 1'b0, 32'h0000_2001, 3'd1, 32'h0,         32'h0000_00A5};
        vecs[2] = '{1'b1, 32'h0000_3000, 3'd4, 32'h1234_5678, 32'h0,         1'b1, 32'h0000_3000, 3'd4, 32'h1234_5678, 32'h0};
        vecs[3] = '{1'b1, 32'h0000_0040, 3'd2, 32'h0000_BEEF, 32'h0,         1'b1, 32'h0000_0040, 3'd2, 32'h0000_BEEF, 32'h0};
        vecs[4] = '{1'b0, 32'h0000_0008, 3'd2, 32'h0,         32'h0000_1234, 1'b0, 32'h0000_0008, 3'd2, 32'h0,         32'h0000_1234};

        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset mcCtl",   {mcEn, mcIf, mcWr}, 3'b000);
        checkOutput("reset mcAddr",  mcAddr, 32'd0);
        checkOutput("reset mcLen",   mcLen, 3'd0);
        checkOutput("reset mcWdata", mcWdata, 32'd0);
        checkOutput("reset dones",   {ifDone, ldDone, stDone}, 3'b000);
        checkOutput("reset ifData",  ifData, '0);
        checkOutput("reset ldData",  ldData, 32'd0);

        // Priority: store, then load, then fetch
        ifReq = 1'b1; ifAddr = 32'h0000_4000;
        ldReq = 1'b1; ldAddr = 32'h0000_5004; ldLen = 3'd4;
        stReq = 1'b1; stAddr = 32'h0000_6008; stLen = 3'd4; stData = 32'hC0FF_EE00;
        waitGrant("prio store", 3);
        checkOutput("prio store mcWr",   mcWr, 1'b1);
        checkOutput("prio store mcAddr", mcAddr, 32'h0000_6008);
        checkOutput("prio store mcWdata", mcWdata, 32'hC0FF_EE00);
        mcLsbDone = 1'b1;
        tick();
        mcLsbDone = 1'b0; stReq = 1'b0;
        checkOutput("prio stDone", stDone, 1'b1);
        waitGrant("prio load", 3);
        checkOutput("prio load mcWr/If", {mcWr, mcIf}, 2'b00);
        checkOutput("prio load mcAddr", mcAddr, 32'h0000_5004);
        mcLsbRdata = 32'h0BAD_F00D; mcLsbDone = 1'b1;
        tick();
        mcLsbDone = 1'b0; ldReq = 1'b0;
        checkOutput("prio ldDone", {ldDone, stDone}, 2'b10);
        checkOutput("prio ldData", ldData, 32'h0BAD_F00D);
        waitGrant("prio fetch", 3);
        checkOutput("prio fetch mcIf", mcIf, 1'b1);
        checkOutput("prio fetch mcAddr", mcAddr, 32'h0000_4000);
        mcIfData = lineA; mcIfDone = 1'b1;
        tick();
        mcIfDone = 1'b0; ifReq = 1'b0;
        checkOutput("prio ifDone", {ifDone, ldDone}, 2'b10);
        checkOutput("prio ifData", ifData, lineA);
        tick();
        checkOutput("prio ifDone pulse", ifDone, 1'b0);

        // Anti-starvation: four loads, then the fetch, then loads again
        ifReq = 1'b1; ifAddr = 32'h0000_7000; ldReq = 1'b1; ldAddr = 32'h0000_0100; ldLen = 3'd4;
        for (int g = 0; g < 6; g++) begin
            waitGrant($sformatf("starve%0d", g), 4);
            checkOutput($sformatf("starve%0d isFetch", g), mcIf, g == 4);
            if (mcIf) mcIfDone = 1'b1;
            else mcLsbDone = 1'b1;
            tick();
            mcIfDone = 1'b0; mcLsbDone = 1'b0;
        end
        ifReq = 1'b0; ldReq = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) applyStimulus(i, vecs[i]);

        // Rollback during fetch: drain silently, then serve the pending load
        ifReq = 1'b1; ifAddr = 32'h0000_8000;
        waitGrant("rbFetch", 3);
        checkOutput("rbFetch mcIf", mcIf, 1'b1);
        rollback = 1'b1; ifReq = 1'b0; ldReq = 1'b1; ldAddr = 32'h0000_0055; ldLen = 3'd2;
        tick();
        rollback = 1'b0;
        checkOutput("rbFetch mcEn", mcEn, 1'b0);
        quietBad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mcEn || ifDone) quietBad++;
        end
        checkOutput("rbFetch drainQuiet", quietBad, 0);
        mcIfData = lineB; mcIfDone = 1'b1;
        tick();
        mcIfDone = 1'b0;
        checkOutput("rbFetch noDone", {ifDone, mcEn}, 2'b00);
        checkOutput("rbFetch ifDataKept", ifData, lineA);
        tick();
        checkOutput("rbFetch loadGrant", {mcEn, mcIf}, 2'b10);
        checkOutput("rbFetch loadAddr", mcAddr, 32'h0000_0055);
        mcLsbDone = 1'b1;
        tick();
        mcLsbDone = 1'b0; ldReq = 1'b0;
        tick();

        // Rollback during store is ignored, even together with the done
        stReq = 1'b1; stAddr = 32'h0000_0900; stLen = 3'd1; stData = 32'h77;
        waitGrant("rbStore", 3);
        rollback = 1'b1;
        tick();
        checkOutput("rbStore mcEn", mcEn, 1'b1);
        mcLsbDone = 1'b1;
        tick();
        mcLsbDone = 1'b0; stReq = 1'b0; rollback = 1'b0;
        checkOutput("rbStore stDone", stDone, 1'b1);
        tick();

        // Rollback during load wins over a simultaneous done
        ldReq = 1'b1; ldAddr = 32'h0000_0A00; ldLen = 3'd4;
        waitGrant("rbLoad", 3);
        rollback = 1'b1; mcLsbDone = 1'b1; mcLsbRdata = 32'hFFFF_FFFF;
        tick();
        rollback = 1'b0; mcLsbDone = 1'b0; ldReq = 1'b0;
        stReq = 1'b1; stAddr = 32'h0000_0B00; stLen = 3'd4; stData = 32'h1;
        checkOutput("rbLoad abort", {mcEn, ldDone}, 2'b00);
        tick();
        checkOutput("rbLoad idleNext", {mcEn, mcWr, ldDone}, 3'b110);
        mcLsbDone = 1'b1;
        tick();
        mcLsbDone = 1'b0; stReq = 1'b0;
        tick();

        // rdy low freezes a busy load
        ldReq = 1'b1; ldAddr = 32'h000C_AFE0; ldLen = 3'd4;
        waitGrant("rdy", 3);
        rdy = 1'b0; mcLsbDone = 1'b1; mcLsbRdata = 32'h11; ldAddr = 32'h0;
        quietBad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!mcEn || mcAddr !== 32'h000C_AFE0 || mcLen !== 3'd4 || ldDone || stDone || ifDone) quietBad++;
        end
        checkOutput("rdy frozen", quietBad, 0);
        rdy = 1'b1; mcLsbRdata = 32'h600D;
        tick();
        mcLsbDone = 1'b0; ldReq = 1'b0;
        checkOutput("rdy ldDone", ldDone, 1'b1);
        checkOutput("rdy ldData", ldData, 32'h600D);
        tick();

        // Reset in the middle of a store
        stReq = 1'b1; stAddr = 32'h0000_0D00; stLen = 3'd2; stData = 32'hABCD;
        waitGrant("rstBusy", 3);
        rst = 1'b1; stReq = 1'b0;
        tick();
        rst = 1'b0;
        checkOutput("rstBusy mcCtl", {mcEn, mcIf, mcWr}, 3'b000);
        checkOutput("rstBusy mcFields", {mcAddr, mcLen, mcWdata}, 67'd0);
        checkOutput("rstBusy data", {ldData, stDone, ldDone, ifDone}, 35'd0);
        checkOutput("rstBusy ifData", ifData, '0);
        ldReq = 1'b1; ldAddr = 32'h0000_0E00;
        tick();
        checkOutput("rstBusy idleNext", mcEn, 1'b1);
        mcLsbDone = 1'b1;
        tick();
        mcLsbDone = 1'b0; ldReq = 1'b0;
        tick();

        // Randomized run against the reference model
        rst = 1'b1;
        modelEdge();
        tick();
        rst = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rdy      = ($urandom_range(7) != 0);
            rollback = ($urandom_range(19) == 0);
            if ($urandom_range(5) == 0) ifReq = !ifReq;
            if ($urandom_range(5) == 0) ldReq = !ldReq;
            if ($urandom_range(5) == 0) stReq = !stReq;
            ifAddr = $urandom; ldAddr = $urandom; stAddr = $urandom; stData = $urandom;
            case ($urandom_range(2))
                0:       ldLen = 3'd1;
                1:       ldLen = 3'd2;
                default: ldLen = 3'd4;
            endcase
            stLen      = 3'($urandom_range(1, 4));
            mcIfDone   = ($urandom_range(5) == 0);
            mcLsbDone  = ($urandom_range(5) == 0);
            mcLsbRdata = $urandom;
            for (int w = 0; w < LW / 32; w++) mcIfData[w*32 +: 32] = $urandom;
            modelEdge();
            tick();
            compareModel(cyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
